cdc_echo_fifo: RTL

Byte FIFO between the USB-CDC serial core's receive side and its send side, in the 60 MHz USB clock domain. It buffers host-to-device bytes and optionally converts lowercase to uppercase. It drains the bytes back to the core under a valid/ready handshake, so an echo no longer loses data when the send buffer is full. It also counts dropped bytes and flushes itself when the USB link resets.

---
 rtl/cdc_echo_fifo_pkg.sv | 24 ++
 rtl/byte_fifo_core.sv | 66 ++++++
 rtl/cdc_echo_fifo.sv | 85 ++++++++
 3 files changed

// File: rtl/cdc_echo_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdc_echo_fifo_pkg
// Description : Shared byte width, ASCII case constants and case-conversion
//               helper for the USB-CDC echo path and later line parsers.
// Revision    : 1.0 - initial release
// ============================================================================
package cdc_echo_fifo_pkg;

    localparam int                      CDC_BYTE_W     = 8;
    localparam logic [CDC_BYTE_W-1:0]   ASCII_LC_LO    = 8'h61;
    localparam logic [CDC_BYTE_W-1:0]   ASCII_LC_HI    = 8'h7A;
    localparam logic [CDC_BYTE_W-1:0]   ASCII_CASE_OFS = 8'h20;

    // Lowercase ASCII letters map to uppercase; every other byte is unchanged.
    function automatic logic [CDC_BYTE_W-1:0] to_upper(input logic [CDC_BYTE_W-1:0] b);
        if ((b >= ASCII_LC_LO) && (b <= ASCII_LC_HI)) begin
            return b - ASCII_CASE_OFS;
        end
        return b;
    endfunction

endpackage : cdc_echo_fifo_pkg
`default_nettype wire

// File: rtl/byte_fifo_core.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo_core
// Description : Generic synchronous FIFO: array, wrapping pointers with one
//               extra bit, occupancy, full and empty. Callers qualify wr_en /
//               rd_en; flush clears both pointers and beats any access.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo_core #(
    parameter int DEPTH_LOG2 = 6,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int                c_DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_COUNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]    r_mem [0:c_DEPTH-1];
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic [DEPTH_LOG2:0] w_count;

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign count   = w_count;
    assign full    = (w_count == c_COUNT_FULL);
    assign empty   = (w_count == '0);
    assign rd_data = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

    // Array storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    // Pointer advance; flush returns both to zero and overrides any access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule : byte_fifo_core
`default_nettype wire

// File: rtl/cdc_echo_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cdc_echo_fifo
// Description : Echo buffer between USB-CDC receive and send sides. Optional
//               lowercase-to-uppercase conversion on write, valid/ready drain,
//               saturating drop counter and flush on USB link reset.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_echo_fifo
    import cdc_echo_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6,
    parameter int UPPERCASE  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   usb_rstn,
    input  logic [CDC_BYTE_W-1:0]  in_data,
    input  logic                   in_valid,
    output logic [CDC_BYTE_W-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DEPTH_LOG2:0]    count,
    output logic                   full,
    output logic                   empty,
    output logic [15:0]            drop_cnt
);

    localparam logic [15:0] c_DROP_MAX = 16'hFFFF;

    logic [CDC_BYTE_W-1:0] w_wr_data;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [15:0]           r_drop_cnt;

    // Conversion happens once, on the way into storage.
    generate
        if (UPPERCASE != 0) begin : g_upper
            assign w_wr_data = to_upper(in_data);
        end else begin : g_pass
            assign w_wr_data = in_data;
        end
    endgenerate

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
    // alongside a pop. Drops are not counted while the link is being flushed.
    assign w_pop  = !w_empty && out_ready;
    assign w_push = in_valid && (!w_full || w_pop);
    assign w_drop = usb_rstn && in_valid && w_full && !w_pop;

    byte_fifo_core #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (CDC_BYTE_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .flush   (!usb_rstn),
        .wr_en   (w_push),
        .wr_data (w_wr_data),
        .rd_en   (w_pop),
        .rd_data (out_data),
        .count   (count),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign full      = w_full;
    assign empty     = w_empty;
    assign out_valid = !w_empty;
    assign drop_cnt  = r_drop_cnt;

    // Saturating count of bytes discarded because the FIFO was full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != c_DROP_MAX)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

endmodule : cdc_echo_fifo
`default_nettype wire
